// File: rtl/matrix_addsub_seq_pkg.sv
// Shared opcodes and FSM state encodings for the sequential matrix add/subtract unit.
package matrix_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/matrix_addsub_seq_elem.sv
// One signed element add/subtract with wrap or saturate; ovf is reported either way.
module matrix_elem_addsub import matrix_pkg::*; #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  input  logic         sat_en,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [W:0] ae, be, s;

  always_comb begin
    ae  = {a[W-1], a};
    be  = {b[W-1], b};
    s   = (op == OP_SUB) ? (ae - be) : (ae + be);
    // sign bit and the extra bit disagree exactly when s left the W-bit range
    ovf = s[W] ^ s[W-1];
    y   = s[W-1:0];
    if (ovf && sat_en)
      y = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/matrix_addsub_seq.sv
// Sequential N x N signed matrix add/subtract, LANES elements per clock, start/done handshake.
module matrix_addsub_seq import matrix_pkg::*; #(
  parameter int N     = 5,
  parameter int W     = 8,
  parameter int LANES = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         op,
  input  logic                         sat_en,
  input  logic [N*N*W-1:0]             matrix_A,
  input  logic [N*N*W-1:0]             matrix_B,
  output logic                         busy,
  output logic                         done,
  output logic [N*N*W-1:0]             result_out,
  output logic                         overflow,
  output logic [$clog2(N*N+1)-1:0]     ovf_count
);

  localparam int NE     = N * N;
  localparam int PASSES = (NE + LANES - 1) / LANES;
  localparam int CW     = $clog2(NE + 1);
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int KW     = $clog2(PASSES * LANES + 1);
  localparam int IW     = (NE > 1) ? $clog2(NE) : 1;

  state_e                  state_q;
  logic [NE-1:0][W-1:0]    a_q, b_q, res_q;
  logic                    op_q, sat_q;
  logic [PW-1:0]           pass_q;
  logic                    ovf_q, busy_q, done_q;
  logic [CW-1:0]           cnt_q;

  logic [LANES-1:0][KW-1:0] lane_k;
  logic [LANES-1:0][IW-1:0] lane_idx;
  logic [LANES-1:0][W-1:0]  lane_y;
  logic [LANES-1:0]         lane_en, lane_ovf;
  logic [CW-1:0]            pass_cnt;
  logic                     last_pass;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // lanes past the last element in the final pass are gated off entirely
    assign lane_k[l]   = KW'(pass_q) * KW'(LANES) + KW'(l);
    assign lane_en[l]  = lane_k[l] < KW'(NE);
    assign lane_idx[l] = lane_en[l] ? IW'(lane_k[l]) : '0;

    matrix_elem_addsub #(.W(W)) u_elem (
      .a      (a_q[lane_idx[l]]),
      .b      (b_q[lane_idx[l]]),
      .op     (op_q),
      .sat_en (sat_q),
      .y      (lane_y[l]),
      .ovf    (lane_ovf[l])
    );
  end

  always_comb begin
    pass_cnt = '0;
    for (int l = 0; l < LANES; l++)
      if (lane_en[l] && lane_ovf[l]) pass_cnt = pass_cnt + CW'(1);
  end

  assign last_pass = (pass_q == PW'(PASSES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      sat_q   <= 1'b0;
      res_q   <= '0;
      pass_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= matrix_A;
            b_q     <= matrix_B;
            op_q    <= op;
            sat_q   <= sat_en;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            pass_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int l = 0; l < LANES; l++)
            if (lane_en[l]) res_q[lane_idx[l]] <= lane_y[l];
          // each element is visited once, so the total cannot exceed NE
          ovf_q <= ovf_q | (|(lane_en & lane_ovf));
          cnt_q <= cnt_q + pass_cnt;
          if (last_pass) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            pass_q <= pass_q + PW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result_out = res_q;
  assign overflow   = ovf_q;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Bench for matrix_addsub_seq: table vectors plus abort/re-start sequences, scoreboard on done.
module tb_matrix_addsub_seq;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int NE = N * N;
  localparam int DW = NE * W;
  localparam int CW = $clog2(NE + 1);

  logic clk = 1'b0;
  logic rst_n, start5, start7, op, sat_en;
  logic [DW-1:0] mA, mB;
  logic busy5, done5, ovf5, busy7, done7, ovf7;
  logic [DW-1:0] res5, res7;
  logic [CW-1:0] cnt5, cnt7;

  always #5 clk = ~clk;

  matrix_addsub_seq #(.N(N), .W(W), .LANES(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start5), .op(op), .sat_en(sat_en),
    .matrix_A(mA), .matrix_B(mB), .busy(busy5), .done(done5),
    .result_out(res5), .overflow(ovf5), .ovf_count(cnt5));

  matrix_addsub_seq #(.N(N), .W(W), .LANES(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(start7), .op(op), .sat_en(sat_en),
    .matrix_A(mA), .matrix_B(mB), .busy(busy7), .done(done7),
    .result_out(res7), .overflow(ovf7), .ovf_count(cnt7));

  typedef struct {
    logic [DW-1:0] a, b;
    logic          op, sat;
    logic [DW-1:0] c;
    logic          ovf;
    logic [CW-1:0] cnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] c;
    logic          ovf;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [W-1:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < NE; k++) r[k*W +: W] = v;
    return r;
  endfunction

  // Reference arithmetic in plain integers, independent of bit tricks.
  function automatic vec_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic o, input logic s);
    vec_t v;
    int x, y, r, maxv, minv;
    maxv = (1 << (W - 1)) - 1;
    minv = -(1 << (W - 1));
    v.a = a; v.b = b; v.op = o; v.sat = s; v.ovf = 1'b0; v.cnt = '0; v.c = '0;
    for (int k = 0; k < NE; k++) begin
      x = int'($signed(a[k*W +: W]));
      y = int'($signed(b[k*W +: W]));
      r = o ? (x - y) : (x + y);
      if (r > maxv) begin
        v.ovf = 1'b1; v.cnt = v.cnt + 1'b1;
        r = s ? maxv : r - (1 << W);
      end else if (r < minv) begin
        v.ovf = 1'b1; v.cnt = v.cnt + 1'b1;
        r = s ? minv : r + (1 << W);
      end
      v.c[k*W +: W] = r[W-1:0];
    end
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the sampling edge.
  task automatic launch(input bit which, input vec_t v, input bit push);
    exp_t e;
    mA = v.a; mB = v.b; op = v.op; sat_en = v.sat;
    if (which) start7 = 1'b1; else start5 = 1'b1;
    if (push) begin
      e.c = v.c; e.ovf = v.ovf; e.cnt = v.cnt;
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start5 = 1'b0;
    start7 = 1'b0;
  endtask

  // Counts edges until done, compares against the scoreboard, ends in IDLE at a negedge.
  task automatic finish_op(input bit which, input string tag, input int exp_lat);
    int n = 0;
    bit got = 1'b0;
    exp_t e;
    while (n < 20 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = which ? done7 : done5;
      if (n == 1 && !got) chk({tag, "_busy"}, which ? busy7 : busy5, 1);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_20", tag);
      return;
    end
    chk({tag, "_latency"}, n, exp_lat);
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard actual=empty required=entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_result"},   which ? res7 : res5, e.c);
    chk({tag, "_overflow"}, which ? ovf7 : ovf5, e.ovf);
    chk({tag, "_count"},    which ? cnt7 : cnt5, e.cnt);
    chk({tag, "_busy_done"}, which ? busy7 : busy5, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulse"}, which ? done7 : done5, 0);
  endtask

  vec_t tbl[8];
  vec_t v;
  logic [DW-1:0] ramp, cexp;
  bit   saw_done;

  initial begin
    rst_n = 1'b0; start5 = 1'b0; start7 = 1'b0; op = 1'b0; sat_en = 1'b0;
    mA = '0; mB = '0;

    // Spec vectors with hand-derived expectations, then model-checked random ones.
    tbl[0] = '{rep(8'd100), rep(8'd27),  1'b1, 1'b0, rep(8'd73),  1'b0, CW'(0)};
    tbl[1] = '{rep(8'h7F),  rep(8'h80),  1'b1, 1'b0, rep(8'hFF),  1'b1, CW'(25)};
    tbl[2] = '{rep(8'h7F),  rep(8'h80),  1'b1, 1'b1, rep(8'h7F),  1'b1, CW'(25)};
    tbl[3] = '{rep(8'h80),  rep(8'hFF),  1'b0, 1'b1, rep(8'h80),  1'b1, CW'(25)};
    cexp = rep(8'hFF); cexp[7:0] = 8'h80;
    tbl[4] = '{{{(DW-8){1'b0}}, 8'h80}, rep(8'hFF), 1'b0, 1'b1, cexp, 1'b1, CW'(1)};
    for (int t = 5; t < 8; t++) begin
      for (int k = 0; k < NE; k++) begin
        mA[k*W +: W] = W'($urandom);
        mB[k*W +: W] = W'($urandom);
      end
      tbl[t] = model(mA, mB, t[0], t[1]);
    end

    repeat (2) @(negedge clk);
    chk("reset_result", res5, 0);
    chk("reset_flags", {busy5, done5, ovf5, cnt5}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      launch(1'b0, tbl[t], 1'b1);
      finish_op(1'b0, $sformatf("vec%0d", t), 5);
    end

    // LANES=7: 4 passes, last pass has only 4 live lanes.
    for (int k = 0; k < NE; k++) begin
      ramp[k*W +: W] = W'(k);
      cexp[k*W +: W] = W'(k + 1);
    end
    v = '{ramp, rep(8'd1), 1'b0, 1'b0, cexp, 1'b0, CW'(0)};
    launch(1'b1, v, 1'b1);
    finish_op(1'b1, "lanes7", 4);
    v = model(rep(8'h7F), rep(8'h01), 1'b0, 1'b0);
    chk("lanes7_model_cnt", v.cnt, 25);
    launch(1'b1, v, 1'b1);
    finish_op(1'b1, "lanes7_ovf", 4);

    // start during RUN with different operands is ignored.
    launch(1'b0, tbl[0], 1'b1);
    mA = rep(8'd5); start5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start5 = 1'b0; mA = rep(8'd9);
    finish_op(1'b0, "restart_ignored", 4);
    // start in the IDLE cycle right after done is accepted.
    launch(1'b0, tbl[3], 1'b1);
    finish_op(1'b0, "back_to_back", 5);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_done |= done5;
    end
    chk("no_extra_done", saw_done, 0);

    // Async reset in pass 2 aborts with no done.
    launch(1'b0, tbl[0], 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", res5, 0);
    chk("abort_flags", {busy5, done5, ovf5, cnt5}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_done |= done5;
    end
    chk("abort_no_done", saw_done, 0);
    launch(1'b0, tbl[1], 1'b1);
    finish_op(1'b0, "after_abort", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
